// File: rtl/dot_product_pkg.sv
// Shared helpers and FSM encodings for the dot-product accumulator.
package dot_product_pkg;

  localparam logic [1:0] ACC   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dot_product_accumulator_multiplier.sv
// Combinational unsigned shift-and-add multiplier; full-width product.
module GenericMultiplier #(
  parameter int bitwidthA = 8,
  parameter int bitwidthB = 8
) (
  input  logic [bitwidthA-1:0]           i_a,
  input  logic [bitwidthB-1:0]           i_b,
  output logic [bitwidthA+bitwidthB-1:0] o_prod
);

  localparam int PW = bitwidthA + bitwidthB;

  logic [PW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < bitwidthB; i++) begin
      if (i_b[i]) begin
        w_sum = w_sum + (PW'(i_a) << i);
      end
    end
  end

  assign o_prod = w_sum;

endmodule

// File: rtl/dot_product_accumulator.sv
// Streams operand pairs, multiplies in a registered stage and accumulates up to
// VECLEN products into one unsigned dot product delivered over valid/ready.
module dot_product_accumulator
  import dot_product_pkg::*;
#(
  parameter  int bitwidthA = 8,
  parameter  int bitwidthB = 8,
  parameter  int VECLEN    = 16,
  localparam int CNTW      = clog2(VECLEN + 1),
  localparam int ACCW      = bitwidthA + bitwidthB + CNTW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bitwidthA-1:0] in_a,
  input  logic [bitwidthB-1:0] in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACCW-1:0]      out_sum,
  output logic [CNTW-1:0]      out_count
);

  localparam int PW = bitwidthA + bitwidthB;

  logic [1:0]           r_state;
  logic [bitwidthA-1:0] r_op_a;
  logic [bitwidthB-1:0] r_op_b;
  logic                 r_last;
  logic                 r_pipe_v;
  logic [CNTW-1:0]      r_cnt;
  logic [ACCW-1:0]      r_acc;
  logic [ACCW-1:0]      r_out_sum;
  logic [CNTW-1:0]      r_out_count;

  logic                 w_accept;
  logic                 w_force_last;
  logic [PW-1:0]        w_prod;
  logic [ACCW-1:0]      w_sum;

  assign in_ready     = (r_state == ACC);
  assign out_valid    = (r_state == HOLD);
  assign out_sum      = r_out_sum;
  assign out_count    = r_out_count;

  assign w_accept     = in_valid & in_ready;
  // The VECLEN-th element closes the vector even without in_last.
  assign w_force_last = in_last | (r_cnt == CNTW'(VECLEN - 1));

  GenericMultiplier #(
    .bitwidthA(bitwidthA),
    .bitwidthB(bitwidthB)
  ) u_mult (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_prod(w_prod)
  );

  assign w_sum = r_acc + ACCW'(w_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACC;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_last      <= 1'b0;
      r_pipe_v    <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      r_pipe_v <= w_accept;
      if (w_accept) begin
        r_op_a <= in_a;
        r_op_b <= in_b;
        r_last <= w_force_last;
        r_cnt  <= r_cnt + CNTW'(1);
      end
      // No accept can occur while the last product drains, so clearing cnt here never collides.
      if (r_pipe_v) begin
        if (r_last) begin
          r_out_sum   <= w_sum;
          r_out_count <= r_cnt;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end

      case (r_state)
        ACC: begin
          if (w_accept && w_force_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= ACC;
          end
        end
        default: begin
          r_state <= ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench: expected sums are queued as vectors are driven and
// compared when the result handshake completes.
module tb_dot_product_accumulator;

  localparam int BWA    = 8;
  localparam int BWB    = 8;
  localparam int VECLEN = 16;
  localparam int CNTW   = 5;
  localparam int ACCW   = BWA + BWB + CNTW;

  typedef struct packed {
    logic [31:0] sum;
    logic [31:0] cnt;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [BWA-1:0]  in_a;
  logic [BWB-1:0]  in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_sum;
  logic [CNTW-1:0] out_count;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fails;
  int   cyc;
  int   last_acc_cyc;
  int   prev_rise;
  int   last_rise;
  logic prev_valid;
  int   m_sum;
  int   m_cnt;

  dot_product_accumulator #(
    .bitwidthA(BWA),
    .bitwidthB(BWB),
    .VECLEN   (VECLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: latency on each new result, scoreboard compare on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        prev_rise = last_rise;
        last_rise = cyc;
        check_value("latency", 32'(cyc - last_acc_cyc), 32'd2);
      end
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_value("out_sum", 32'(out_sum), e.sum);
          check_value("out_count", 32'(out_count), e.cnt);
          $display("result sum=%0d count=%0d at cycle %0d", out_sum, out_count, cyc);
        end
      end
    end
  end

  task automatic send(input int a, input int b, input bit last);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_a     = BWA'(a);
    in_b     = BWB'(b);
    in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        m_sum += a * b;
        m_cnt++;
        if (last || m_cnt == VECLEN) begin
          exp_t e;
          e.sum = 32'(m_sum);
          e.cnt = 32'(m_cnt);
          exp_q.push_back(e);
          last_acc_cyc = cyc;
          m_sum = 0;
          m_cnt = 0;
        end
        @(posedge clk);
        #1;
      end
    end
    if (!done) check_value("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check_value("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    m_sum    = 0;
    m_cnt    = 0;
    exp_q.delete();
    @(negedge clk);
    check_value("rst_in_ready", 32'(in_ready), 32'd1);
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_out_sum", 32'(out_sum), 32'd0);
    check_value("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int held;
    n_checks     = 0;
    n_fails      = 0;
    last_acc_cyc = 0;
    prev_rise    = 0;
    last_rise    = 0;
    prev_valid   = 1'b0;
    m_sum        = 0;
    m_cnt        = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_last      = 1'b0;
    out_ready    = 1'b1;
    #2;
    apply_reset();

    // Basic vector: 1*5+2*6+3*7+4*8 = 70
    for (int i = 1; i <= 4; i++) send(i, i + 4, i == 4);
    wait_done();

    // Forced last at VECLEN without in_last: 16*255*255 = 1040400
    for (int i = 0; i < VECLEN; i++) send(255, 255, 1'b0);
    @(negedge clk);
    check_value("forced_last_in_ready", 32'(in_ready), 32'd0);
    wait_done();

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    send(3, 5, 1'b0);
    send(4, 6, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check_value("hold_valid_seen", 32'(out_valid), 32'd1);
    held = 39;
    for (int i = 0; i < 5; i++) begin
      check_value("hold_sum", 32'(out_sum), 32'(held));
      check_value("hold_in_ready", 32'(in_ready), 32'd0);
      check_value("hold_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_value("post_hs_in_ready", 32'(in_ready), 32'd1);
    check_value("post_hs_out_valid", 32'(out_valid), 32'd0);
    check_value("post_hs_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Gaps inside a vector: 3 * 9 = 27
    send(3, 3, 1'b0);
    idle(2);
    send(3, 3, 1'b0);
    send(3, 3, 1'b1);
    wait_done();

    // Abort mid-vector with reset, then a clean 2*2+2*2 = 8 vector
    send(7, 7, 1'b0);
    send(9, 9, 1'b0);
    apply_reset();
    send(2, 2, 1'b0);
    send(2, 2, 1'b1);
    wait_done();

    // Back-to-back single-element vectors
    send(9, 9, 1'b1);
    send(10, 10, 1'b1);
    wait_done();
    check_value("b2b_spacing", 32'(last_rise - prev_rise), 32'd3);

    repeat (3) @(posedge clk);
    check_value("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
